mcp4922_rx: RTL

SPI receiver for the MCP4922 dual-DAC command stream: samples the SCK/CS_n/SDI lines that the vector pipeline drives toward the DAC and decodes each 16-bit frame back into channel, configuration bits and 12-bit value. It reassembles consecutive channel-A/channel-B writes into (x, y) beam positions. It sits beside the line-drawing path as a loopback monitor, for on-chip self-check or for logic-analyzer export, and can also act as a bench-side DAC model.

---
 rtl/mcp4922_pkg.sv | 12 +
 rtl/mcp4922_rx_sync_edge.sv | 30 +++
 rtl/mcp4922_rx.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mcp4922_pkg.sv
// Frame layout and receiver state encoding for the MCP4922 command stream.
// Shared by the transmit-side DAC driver and the loopback receiver.
package mcp4922_pkg;
    localparam int FRAME_BITS = 16;
    localparam int AXIS_BIT   = 15;
    localparam int BUF_BIT    = 14;
    localparam int GA_BIT     = 13;
    localparam int SHDN_BIT   = 12;
    localparam int VALUE_MSB  = 11;

    typedef enum logic [1:0] {SKIP, IDLE, RECV, OVERRUN} rx_state_t;
endpackage

// File: rtl/mcp4922_rx_sync_edge.sv
// N-stage synchronizer with a trailing edge-detect flop and rise/fall pulses.
module sync_edge #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);
    logic [N-1:0] r_sync;
    logic         r_last;

    // Reset to a caller-chosen level so release of reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {N{RST_VAL}};
            r_last <= RST_VAL;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
            r_last <= r_sync[N-1];
        end
    end

    assign o_q    = r_sync[N-1];
    assign o_rise = r_sync[N-1] & ~r_last;
    assign o_fall = ~r_sync[N-1] & r_last;
endmodule

// File: rtl/mcp4922_rx.sv
// MCP4922 SPI loopback receiver: decodes 16-bit DAC frames and pairs
// consecutive A/B writes into (x, y) beam positions.
module mcp4922_rx
    import mcp4922_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_sdi,
    output logic        word_valid,
    output logic        word_axis,
    output logic        word_buf,
    output logic        word_gain_n,
    output logic        word_shdn_n,
    output logic [11:0] word_value,
    output logic        frame_err,
    output logic [11:0] x_out,
    output logic [11:0] y_out,
    output logic        point_valid
);
    localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

    logic w_sck_q, w_sck_rise, w_sck_fall;
    logic w_cs_q, w_cs_rise, w_cs_fall;
    logic w_sdi;
    logic w_sck_unused;

    sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .reset(reset), .i_d(spi_sck),
        .o_q(w_sck_q), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    // cs_n syncs reset low so SKIP waits for a genuinely observed high level.
    sync_edge #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_cs (
        .clk(clk), .reset(reset), .i_d(spi_cs_n),
        .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    assign w_sck_unused = w_sck_q ^ w_sck_fall;

    logic [SYNC_STAGES-1:0] r_sdi_sync;
    always_ff @(posedge clk) begin
        if (reset) r_sdi_sync <= '0;
        else       r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi};
    end
    assign w_sdi = r_sdi_sync[SYNC_STAGES-1];

    rx_state_t   r_state;
    logic [15:0] r_shift;
    logic [4:0]  r_count;
    logic        r_done_ok;
    logic        r_done_err;
    logic        r_pending_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SKIP;
            r_shift     <= '0;
            r_count     <= '0;
            r_done_ok   <= 1'b0;
            r_done_err  <= 1'b0;
            word_axis   <= 1'b0;
            word_buf    <= 1'b0;
            word_gain_n <= 1'b0;
            word_shdn_n <= 1'b0;
            word_value  <= '0;
        end else begin
            r_done_ok  <= 1'b0;
            r_done_err <= 1'b0;
            case (r_state)
                SKIP: if (w_cs_q) r_state <= IDLE;
                IDLE: if (w_cs_fall) begin
                    r_shift <= '0;
                    r_count <= '0;
                    r_state <= RECV;
                end
                RECV: if (w_cs_rise) begin
                    if (r_count == FRAME_CNT) begin
                        r_done_ok   <= 1'b1;
                        word_axis   <= r_shift[AXIS_BIT];
                        word_buf    <= r_shift[BUF_BIT];
                        word_gain_n <= r_shift[GA_BIT];
                        word_shdn_n <= r_shift[SHDN_BIT];
                        word_value  <= r_shift[VALUE_MSB:0];
                    end else begin
                        r_done_err <= 1'b1;
                    end
                    r_state <= IDLE;
                end else if (w_sck_rise) begin
                    if (r_count == FRAME_CNT) begin
                        r_state <= OVERRUN;
                    end else begin
                        r_shift <= {r_shift[14:0], w_sdi};
                        r_count <= r_count + 5'd1;
                    end
                end
                OVERRUN: if (w_cs_rise) begin
                    r_done_err <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= SKIP;
            endcase
        end
    end

    // Pulses and positions trail the field load by one cycle so word_* are stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_valid  <= 1'b0;
            frame_err   <= 1'b0;
            point_valid <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            r_pending_x <= 1'b0;
        end else begin
            word_valid  <= r_done_ok;
            frame_err   <= r_done_err;
            point_valid <= 1'b0;
            if (r_done_ok && word_shdn_n) begin
                if (!word_axis) begin
                    x_out       <= word_value;
                    r_pending_x <= 1'b1;
                end else begin
                    y_out       <= word_value;
                    point_valid <= r_pending_x;
                    r_pending_x <= 1'b0;
                end
            end
        end
    end
endmodule
